nibble_serial_addsub: RTL and testbench
=======================================

// Module: nibble_serial_addsub
// PURPOSE
//  Multi-cycle WIDTH-bit adder/subtractor. Processes one 4-bit nibble per clock, LSB first,
//  through a single 4-bit add/sub slice (the same slice the four-bit full adder/subtractor tests exercise).
//  Sits downstream of the operand source in the arithmetic datapath; consumed by result/register logic.
//  Start/done handshake; result held until the next accepted operation.
// PARAMETERS
//  WIDTH  16  operand/result width; must be a multiple of 4 and >= 8 (elaboration $fatal otherwise)
// PORTS
//  clk_i    in   1      clock; all state changes on the rising edge
//  rst_i    in   1      reset; asynchronous, active-high
//  start_i  in   1      request; sampled only in IDLE or DONE
//  sub_i    in   1      0: a_i + b_i, 1: a_i - b_i; latched with start
//  a_i      in   WIDTH  operand A; latched with start
//  b_i      in   WIDTH  operand B; latched with start
//  busy_o   out  1      high while state == RUN
//  done_o   out  1      one-cycle pulse, high while state == DONE
//  res_o    out  WIDTH  result (two's complement, modulo 2^WIDTH)
//  cout_o   out  1      carry out of the MSB (for sub: 1 = no borrow)
//  ovf_o    out  1      signed overflow: carry into MSB XOR carry out of MSB
// BEHAVIOUR
//  - Reset: state IDLE; busy_o, done_o, res_o, cout_o, ovf_o = 0; nibble index and carry = 0. Abort mid-RUN is immediate.
//  - FSM: IDLE --start_i--> RUN; RUN --last nibble--> DONE; DONE --start_i--> RUN, else --> IDLE.
//  - Start edge: latch a_i; latch b_i, inverted when sub_i=1; carry = sub_i; index = 0.
//  - RUN, each edge: slice adds nibble[index] of A and B' with carry. Write the 4-bit sum into working register nibble[index].
//    Update carry; index++. Record carry-into-MSB on the last nibble.
//  - Latency: NIB = WIDTH/4. done_o is high in the cycle after the NIB-th edge following the start edge.
//    WIDTH=16: start sampled at edge 0, done_o high between edges 4 and 5.
//  - res_o/cout_o/ovf_o are output registers. They load only on the edge entering DONE, so they never show partial sums.
//    They hold until the next DONE or reset.
//  - start_i during RUN is ignored (no queueing; operands not re-latched).
//  - start_i in DONE: back-to-back accept; done_o still pulses for exactly one cycle.
//  - a_i/b_i/sub_i changes after the start edge have no effect on the running operation.
// CONFIGURATION
//  NIBBLE_ADDSUB_SAT_EN defined: when the signed-overflow bit computed on the final nibble is set, res_o saturates.
//    res_o = {1'b0,{WIDTH-1{1'b1}}} when the true result is positive (MSBs of A and B' both 0).
//    res_o = {1'b1,{WIDTH-1{1'b0}}} when it is negative.
//    ovf_o still reports 1; cout_o unchanged.
//  Not defined: res_o wraps modulo 2^WIDTH; no saturation logic is generated.
// STRUCTURE
//  - Package nibble_addsub_pkg: NIBBLE_W = 4; typedef enum logic [1:0] {IDLE, RUN, DONE} nibble_addsub_state_t.
//  - Sub-module four_bit_addsub_slice: combinational, 4-bit a, 4-bit b, cin -> 4-bit sum, cout, c3 (carry into bit 3).
//    Instantiated once.
//  - Top: FSM, index counter ($clog2(NIB) bits), working register, carry flop, output registers.
// TESTING (WIDTH=16; bench test class nibble_serial_addsub_test_generic, selectable via TESTNAME)
//  1. a=0x1234 b=0x4321 sub=0 -> res=0x5555 cout=0 ovf=0. busy 4 cycles; done_o exactly 1 cycle, 4 edges after start.
//  2. a=0xFFFF b=0x0001 sub=0 -> res=0x0000 cout=1 ovf=0.
//  3. a=0x7FFF b=0x0001 sub=0 -> res=0x8000 cout=0 ovf=1 (SAT_EN: res=0x7FFF).
//  4. a=0x0000 b=0x0001 sub=1 -> res=0xFFFF cout=0 ovf=0. Then a=0x8000 b=0x0001 sub=1 -> res=0x7FFF cout=1 ovf=1 (SAT_EN: res=0x8000).
//  5. start pulsed in RUN with other operands -> ignored, first result unchanged. start held in DONE -> back-to-back op.
//     Second done_o follows 4 edges later.
//  6. Assert rst_i asynchronously 2 cycles into RUN -> all outputs 0 immediately, state IDLE.
//     Next op a=0x0003 b=0x0004 -> res=0x0007.

Source files
------------

// File: rtl/nibble_addsub_pkg.sv
// Shared constants and state encoding for the nibble-serial add/sub unit.
package nibble_addsub_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } nibble_addsub_state_t;

endpackage

// File: rtl/nibble_serial_addsub_slice.sv
// Four-bit ripple add/sub slice; exposes the carry into bit 3
// so the caller can derive signed overflow on the top nibble.
module four_bit_addsub_slice (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_sum,
  output logic       o_cout,
  output logic       o_c3
);

  logic [4:0] w_c;

  always_comb begin
    w_c    = '0;
    o_sum  = '0;
    w_c[0] = i_cin;
    for (int i = 0; i < 4; i++) begin
      o_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
      w_c[i+1]  = (i_a[i] & i_b[i]) |
                  (i_a[i] & w_c[i]) |
                  (i_b[i] & w_c[i]);
    end
  end

  assign o_cout = w_c[4];
  assign o_c3   = w_c[3];

endmodule

// File: rtl/nibble_serial_addsub.sv
// Multi-cycle add/sub, one nibble per clock, LSB first.
// Define NIBBLE_ADDSUB_SAT_EN to saturate res_o on signed overflow.
import nibble_addsub_pkg::*;

module nibble_serial_addsub #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             sub_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] res_o,
  output logic             cout_o,
  output logic             ovf_o
);

  localparam int NIB = WIDTH / NIBBLE_W;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIB - 1);

  if ((WIDTH % NIBBLE_W) != 0 || WIDTH < 8) begin : g_bad_width
    $fatal(1, "nibble_serial_addsub: bad WIDTH");
  end

  nibble_addsub_state_t r_state;
  nibble_addsub_state_t w_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_work;
  logic [IW-1:0]    r_idx;
  logic             r_carry;
  logic [WIDTH-1:0] r_res;
  logic             r_cout;
  logic             r_ovf;

  logic             w_accept;
  logic             w_last;
  logic [3:0]       w_na;
  logic [3:0]       w_nb;
  logic [3:0]       w_sum;
  logic             w_cout;
  logic             w_c3;
  logic             w_ovf;
  logic [WIDTH-1:0] w_full;
  logic [WIDTH-1:0] w_res;

  assign w_accept = start_i && (r_state != RUN);
  assign w_last   = (r_idx == LAST);
  assign w_na     = r_a[r_idx*NIBBLE_W +: NIBBLE_W];
  assign w_nb     = r_b[r_idx*NIBBLE_W +: NIBBLE_W];

  four_bit_addsub_slice u_slice (
    .i_a    (w_na),
    .i_b    (w_nb),
    .i_cin  (r_carry),
    .o_sum  (w_sum),
    .o_cout (w_cout),
    .o_c3   (w_c3)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (start_i) w_next = RUN;
      RUN:     if (w_last)  w_next = DONE;
      DONE:    w_next = start_i ? RUN : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Top nibble comes straight from the slice on the final edge.
  always_comb begin
    w_full = r_work;
    w_full[WIDTH-1 -: NIBBLE_W] = w_sum;
  end

  assign w_ovf = w_c3 ^ w_cout;

`ifdef NIBBLE_ADDSUB_SAT_EN
  always_comb begin
    w_res = w_full;
    if (w_ovf) begin
      if (!r_a[WIDTH-1] && !r_b[WIDTH-1])
        w_res = {1'b0, {(WIDTH-1){1'b1}}};
      else
        w_res = {1'b1, {(WIDTH-1){1'b0}}};
    end
  end
`else
  assign w_res = w_full;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_a     <= '0;
      r_b     <= '0;
      r_work  <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a_i;
      r_b     <= sub_i ? ~b_i : b_i;
      r_carry <= sub_i;
      r_idx   <= '0;
    end else if (r_state == RUN) begin
      r_work[r_idx*NIBBLE_W +: NIBBLE_W] <= w_sum;
      r_carry <= w_cout;
      r_idx   <= r_idx + IW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_res  <= '0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (r_state == RUN && w_last) begin
      r_res  <= w_res;
      r_cout <= w_cout;
      r_ovf  <= w_ovf;
    end
  end

  assign busy_o = (r_state == RUN);
  assign done_o = (r_state == DONE);
  assign res_o  = r_res;
  assign cout_o = r_cout;
  assign ovf_o  = r_ovf;

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Scoreboard bench for nibble_serial_addsub (WIDTH=16).
// Expected results are queued at issue and checked on each done_o.
module tb_nibble_serial_addsub;

  localparam string TESTNAME = "nibble_serial_addsub_test_generic";

`ifdef NIBBLE_ADDSUB_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    logic [15:0] res;
    logic        cout;
    logic        ovf;
    string       nm;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic        sub_i = 1'b0;
  logic [15:0] a_i = '0;
  logic [15:0] b_i = '0;
  logic        busy_o;
  logic        done_o;
  logic [15:0] res_o;
  logic        cout_o;
  logic        ovf_o;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  nibble_serial_addsub #(.WIDTH(16)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i),
    .sub_i   (sub_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .res_o   (res_o),
    .cout_o  (cout_o),
    .ovf_o   (ovf_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  always @(negedge clk_i) begin
    if (!rst_i && done_o) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done act=%h exp=none", res_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.nm, "_res"},  32'(res_o),  32'(e.res));
        chk({e.nm, "_cout"}, 32'(cout_o), 32'(e.cout));
        chk({e.nm, "_ovf"},  32'(ovf_o),  32'(e.ovf));
      end
    end
  end

  task automatic issue(input logic [15:0] a, input logic [15:0] b,
                       input logic s, input logic [15:0] er,
                       input logic ec, input logic eo,
                       input string nm);
    exp_t e;
    a_i = a;
    b_i = b;
    sub_i = s;
    start_i = 1'b1;
    e.res = er;
    e.cout = ec;
    e.ovf = eo;
    e.nm = nm;
    sb.push_back(e);
  endtask

  // Called at the negedge following the start edge.
  task automatic wait_done(input string nm);
    int n = 0;
    int bn = 0;
    chk({nm, "_busy0"}, 32'(busy_o), 32'd1);
    while (!done_o && n < 20) begin
      if (busy_o) bn++;
      @(negedge clk_i);
      n++;
    end
    chk({nm, "_latency"}, 32'(n), 32'd4);
    chk({nm, "_busycyc"}, 32'(bn), 32'd4);
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input logic s, input logic [15:0] er,
                        input logic ec, input logic eo,
                        input string nm);
    @(negedge clk_i);
    issue(a, b, s, er, ec, eo, nm);
    @(negedge clk_i);
    start_i = 1'b0;
    a_i = ~a;
    b_i = ~b;
    sub_i = ~s;
    wait_done(nm);
    @(negedge clk_i);
    chk({nm, "_donepulse"}, 32'(done_o), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    $display("running %s", TESTNAME);
    #12;
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_res",  32'(res_o),  32'd0);
    chk("rst_cout", 32'(cout_o), 32'd0);
    chk("rst_ovf",  32'(ovf_o),  32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;

    run_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, "t1");
    run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, "t2");
    run_op(16'h7FFF, 16'h0001, 1'b0, SAT ? 16'h7FFF : 16'h8000,
           1'b0, 1'b1, "t3");
    repeat (3) @(negedge clk_i);
    chk("t3_hold_res", 32'(res_o), SAT ? 32'h7FFF : 32'h8000);
    chk("t3_hold_ovf", 32'(ovf_o), 32'd1);
    run_op(16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0, "t4a");
    run_op(16'h8000, 16'h0001, 1'b1, SAT ? 16'h8000 : 16'h7FFF,
           1'b1, 1'b1, "t4b");

    @(negedge clk_i);
    issue(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, "t5a");
    @(negedge clk_i);
    start_i = 1'b0;
    @(negedge clk_i);
    a_i = 16'hAAAA;
    b_i = 16'h1111;
    sub_i = 1'b1;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    n = 0;
    while (!done_o && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    chk("t5a_latency_rest", 32'(n), 32'd2);
    issue(16'h00FF, 16'h0F01, 1'b1, 16'hF1FE, 1'b0, 1'b0, "t5b");
    @(negedge clk_i);
    start_i = 1'b0;
    chk("t5_b2b_donepulse", 32'(done_o), 32'd0);
    wait_done("t5b");
    @(negedge clk_i);
    chk("t5b_donepulse", 32'(done_o), 32'd0);

    @(negedge clk_i);
    a_i = 16'hFFFF;
    b_i = 16'hFFFF;
    sub_i = 1'b0;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    chk("t6_abort_busy", 32'(busy_o), 32'd0);
    chk("t6_abort_done", 32'(done_o), 32'd0);
    chk("t6_abort_res",  32'(res_o),  32'd0);
    chk("t6_abort_cout", 32'(cout_o), 32'd0);
    chk("t6_abort_ovf",  32'(ovf_o),  32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (6) @(negedge clk_i);
    chk("t6_idle_busy", 32'(busy_o), 32'd0);
    chk("t6_idle_done", 32'(done_o), 32'd0);
    run_op(16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0, "t6");

    repeat (2) @(negedge clk_i);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
